// File: rtl/xor_unit_arbiter_pkg.sv
// ============================================================================
// Module  : xor_unit_arbiter_pkg
// Brief   : Shared state encodings and datapath width for the XOR arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package xor_unit_arbiter_pkg;

  localparam int DATA_W = 20;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/twenty_bit_bitwise_xor.sv
// ============================================================================
// Module  : twenty_bit_bitwise_xor
// Brief   : 20-bit bitwise XOR datapath shared by the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module twenty_bit_bitwise_xor (
  input  logic [19:0] i0,
  input  logic [19:0] i1,
  output logic [19:0] s
);

  assign s = i0 ^ i1;

endmodule

`default_nettype wire

// File: rtl/xor_unit_arbiter_rr_picker.sv
// ============================================================================
// Module  : xor_unit_arbiter_rr_picker
// Brief   : Combinational round-robin picker, searching upward from last+1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xor_unit_arbiter_rr_picker #(
  parameter  int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] last,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            any
);

  assign any = |req;

  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    // Offsets 1..NREQ visit every requester once, ending on last itself.
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/xor_unit_arbiter.sv
// ============================================================================
// Module  : xor_unit_arbiter
// Brief   : Round-robin sharing of one XOR datapath, one op in flight.
// Revision: 1.0
// ============================================================================
`default_nettype none

module xor_unit_arbiter
  import xor_unit_arbiter_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int CNT_W = 16,
  localparam int ID_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_data,
  output logic [ID_W-1:0]        rsp_id,
  input  logic                   rsp_ready,
  output logic                   busy,
  output logic [CNT_W-1:0]       op_count
);

  state_e              r_state;
  logic [ID_W-1:0]     r_last;
  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;

  logic [NREQ-1:0]     w_gnt;
  logic [ID_W-1:0]     w_gnt_id;
  logic                w_any;
  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [DATA_W-1:0]   w_xor;

  xor_unit_arbiter_rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (req_valid),
    .last   (r_last),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id),
    .any    (w_any)
  );

  twenty_bit_bitwise_xor u_xor (
    .i0 (r_a),
    .i1 (r_b),
    .s  (w_xor)
  );

  assign w_sel_a = req_a[int'(w_gnt_id)*DATA_W +: DATA_W];
  assign w_sel_b = req_b[int'(w_gnt_id)*DATA_W +: DATA_W];

  // Grants are only offered from IDLE and never while reset is asserted.
  assign req_ready = (rst_n && (r_state == IDLE)) ? w_gnt : '0;
  assign busy      = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_last    <= ID_W'(NREQ - 1);
      r_id      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      op_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_id    <= w_gnt_id;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= w_xor;
          rsp_id    <= r_id;
          rsp_valid <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            r_last    <= rsp_id;
            if (op_count != {CNT_W{1'b1}}) begin
              op_count <= op_count + CNT_W'(1);
            end
            r_state   <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
